// File: rtl/seven_seg_pkg.sv
// Shared types and segment decode for the seven-segment display stage.
// Segment bytes are {dp,g,f,e,d,c,b,a}, active-low, decimal point off.
package seven_seg_pkg;

    typedef logic [1:0] digitIdx_t;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;

    localparam logic [7:0] SEG_OFF   = 8'hFF;
    localparam logic [3:0] ANODE_OFF = 4'hF;

    function automatic logic [7:0] hexToSegment(input logic [3:0] nibble);
        logic [7:0] seg;
        unique case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_scan_prescaler.sv
// Free-running divider: counts 0..DIVIDE_COUNT-1, tick marks the wrap cycle.
// Sized by COUNTER_WIDTH, which must hold DIVIDE_COUNT-1.
module scan_prescaler #(
    parameter int DIVIDE_COUNT  = 100000,
    parameter int COUNTER_WIDTH = 18
) (
    input  logic cmosClock,
    input  logic resetN,
    output logic tick
);

    localparam logic [COUNTER_WIDTH-1:0] LAST =
        COUNTER_WIDTH'(DIVIDE_COUNT - 1);

    logic [COUNTER_WIDTH-1:0] count;

    assign tick = (count == LAST);

    // Dwell counter, wraps to zero on the tick cycle.
    always_ff @(posedge cmosClock or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with tear-free value commit.
// Optional: define LEADING_ZERO_BLANK_EN to dark leading zero digits 3..1.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int DIVIDE_COUNT  = 100000,
    parameter int COUNTER_WIDTH = 18
) (
    input  logic        cmosClock,
    input  logic        resetN,
    input  logic [15:0] displayValue,
    input  logic [3:0]  dpMask,
    input  logic        valueValid,
    input  logic        blankEnable,
    output logic        loadAck,
    output logic [3:0]  sevenSegmentEnable,
    output logic [7:0]  sevenSegmentData
);

    logic        tick;
    logic        wrapTick;
    logic        commitNow;
    logic        pending;
    digitIdx_t   digitIndex;
    digitIdx_t   nextIndex;
    logic [15:0] shadowValue;
    logic [15:0] pendingValue;
    logic [15:0] commitValue;
    logic [15:0] frameValue;
    logic [3:0]  shadowDp;
    logic [3:0]  pendingDp;
    logic [3:0]  commitDp;
    logic [3:0]  frameDp;
    logic [3:0]  nibble;
    logic [7:0]  segRaw;
    logic [7:0]  segByte;
    logic        leadingBlank;

    scan_prescaler #(
        .DIVIDE_COUNT (DIVIDE_COUNT),
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) uPrescaler (
        .cmosClock(cmosClock),
        .resetN   (resetN),
        .tick     (tick)
    );

    assign nextIndex = digitIndex + 2'd1;
    assign wrapTick  = tick && (digitIndex == 2'd3);
    assign commitNow = wrapTick && (valueValid || pending);

    // Pick the frame contents; a commit edge decodes the incoming value.
    always_comb begin
        commitValue = pending ? pendingValue : shadowValue;
        commitDp    = pending ? pendingDp : shadowDp;
        if (valueValid) begin
            commitValue = displayValue;
            commitDp    = dpMask;
        end
        frameValue = commitNow ? commitValue : shadowValue;
        frameDp    = commitNow ? commitDp : shadowDp;
        nibble     = frameValue[4*nextIndex +: 4];
        segRaw     = hexToSegment(nibble);
        segByte    = {~frameDp[nextIndex], segRaw[6:0]};
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] zeroDigit;

    // A digit is a leading zero when it and all higher digits are bare zeros.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            zeroDigit[k] = (frameValue[4*k +: 4] == 4'h0) && !frameDp[k];
        end
        case (nextIndex)
            2'd3:    leadingBlank = zeroDigit[3];
            2'd2:    leadingBlank = &zeroDigit[3:2];
            2'd1:    leadingBlank = &zeroDigit[3:1];
            default: leadingBlank = 1'b0;
        endcase
    end
`else
    assign leadingBlank = 1'b0;
`endif

    // Scan index and registered display outputs, updated on ticks only.
    always_ff @(posedge cmosClock or negedge resetN) begin
        if (!resetN) begin
            digitIndex         <= 2'd3;
            sevenSegmentEnable <= ANODE_OFF;
            sevenSegmentData   <= SEG_OFF;
        end else if (tick) begin
            digitIndex <= nextIndex;
            if (blankEnable || leadingBlank) begin
                sevenSegmentEnable <= ANODE_OFF;
                sevenSegmentData   <= SEG_OFF;
            end else begin
                sevenSegmentEnable <= ~(4'b0001 << nextIndex);
                sevenSegmentData   <= segByte;
            end
        end
    end

    // Load buffer and frame-boundary commit into the shadow registers.
    always_ff @(posedge cmosClock or negedge resetN) begin
        if (!resetN) begin
            shadowValue  <= '0;
            shadowDp     <= '0;
            pendingValue <= '0;
            pendingDp    <= '0;
            pending      <= 1'b0;
            loadAck      <= 1'b0;
        end else begin
            loadAck <= commitNow;
            if (commitNow) begin
                shadowValue <= commitValue;
                shadowDp    <= commitDp;
                pending     <= 1'b0;
            end else if (valueValid) begin
                pendingValue <= displayValue;
                pendingDp    <= dpMask;
                pending      <= 1'b1;
            end
        end
    end

endmodule
